// File: rtl/main_fsm.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback and drives
// the datapath enables, mux selects and ALUOp, with a memory-ready stall and illegal trap.
module main_fsm #(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [6:0]         op_i,
    input  logic               zero_i,
    input  logic               mem_ready_i,
    output logic               ir_write_o,
    output logic               pc_write_o,
    output logic               reg_write_o,
    output logic               mem_write_o,
    output logic               adr_src_o,
    output logic [1:0]         result_src_o,
    output logic [1:0]         alu_src_a_o,
    output logic [1:0]         alu_src_b_o,
    output logic [1:0]         alu_op_o,
    output logic               illegal_o,
    output logic [STATE_W-1:0] dbg_state_o
);

    localparam logic [6:0] OpLw    = 7'b0000011;
    localparam logic [6:0] OpSw    = 7'b0100011;
    localparam logic [6:0] OpRtype = 7'b0110011;
    localparam logic [6:0] OpItype = 7'b0010011;
    localparam logic [6:0] OpBeq   = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;

    typedef enum logic [STATE_W-1:0] {
        StFetch    = 0,
        StDecode   = 1,
        StMemAdr   = 2,
        StMemRead  = 3,
        StMemWb    = 4,
        StMemWrite = 5,
        StExecuteR = 6,
        StExecuteI = 7,
        StAluWb    = 8,
        StBeq      = 9,
        StJal      = 10,
        StTrap     = 11
    } state_e;

    state_e state_q, state_d;
    logic   illegal_q, illegal_d;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Sticky: set on entry to the trap state, cleared only by reset.
    assign illegal_d   = illegal_q | (state_d == StTrap);
    assign illegal_o   = illegal_q;
    assign dbg_state_o = state_q;

    always_comb begin
        state_d      = state_q;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        reg_write_o  = 1'b0;
        mem_write_o  = 1'b0;
        adr_src_o    = 1'b0;
        result_src_o = 2'b00;
        alu_src_a_o  = 2'b00;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 2'b00;

        unique case (state_q)
            StFetch: begin
                alu_src_b_o  = 2'b10;
                result_src_o = 2'b10;
                ir_write_o   = mem_ready_i;
                pc_write_o   = mem_ready_i;
                if (mem_ready_i) state_d = StDecode;
            end
            StDecode: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b01;
                unique case (op_i)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StExecuteR;
                    OpItype:    state_d = StExecuteI;
                    OpBeq:      state_d = StBeq;
                    OpJal:      state_d = StJal;
                    default:    state_d = StTrap;
                endcase
            end
            StMemAdr: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
                state_d     = (op_i == OpLw) ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                adr_src_o = 1'b1;
                if (mem_ready_i) state_d = StMemWb;
            end
            StMemWb: begin
                result_src_o = 2'b01;
                reg_write_o  = 1'b1;
                state_d      = StFetch;
            end
            StMemWrite: begin
                adr_src_o   = 1'b1;
                mem_write_o = 1'b1;
                if (mem_ready_i) state_d = StFetch;
            end
            StExecuteR: begin
                alu_src_a_o = 2'b10;
                alu_op_o    = 2'b10;
                state_d     = StAluWb;
            end
            StExecuteI: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
                alu_op_o    = 2'b10;
                state_d     = StAluWb;
            end
            StAluWb: begin
                reg_write_o = 1'b1;
                state_d     = StFetch;
            end
            StBeq: begin
                alu_src_a_o = 2'b10;
                alu_op_o    = 2'b01;
                pc_write_o  = zero_i;
                state_d     = StFetch;
            end
            StJal: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b10;
                pc_write_o  = 1'b1;
                state_d     = StAluWb;
            end
            StTrap: state_d = StTrap;
            default: state_d = StTrap;
        endcase
    end

endmodule

// File: tb/tb_main_fsm.sv
// Self-checking bench for main_fsm: directed scenarios plus randomized instruction streams
// checked cycle-by-cycle against a per-instruction expected-sequence model.
module tb_main_fsm;

    localparam logic [6:0] OpLw    = 7'b0000011;
    localparam logic [6:0] OpSw    = 7'b0100011;
    localparam logic [6:0] OpRtype = 7'b0110011;
    localparam logic [6:0] OpItype = 7'b0010011;
    localparam logic [6:0] OpBeq   = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpLui   = 7'b0110111;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic [6:0] op_i = 7'd0;
    logic       zero_i = 1'b0;
    logic       mem_ready_i = 1'b0;
    logic       ir_write_o, pc_write_o, reg_write_o, mem_write_o, adr_src_o, illegal_o;
    logic [1:0] result_src_o, alu_src_a_o, alu_src_b_o, alu_op_o;
    logic [3:0] dbg_state_o;
    logic [13:0] got;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int st;
        bit mr;
        bit z;
    } cyc_t;
    cyc_t q[$];

    main_fsm #(.STATE_W(4)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .op_i        (op_i),
        .zero_i      (zero_i),
        .mem_ready_i (mem_ready_i),
        .ir_write_o  (ir_write_o),
        .pc_write_o  (pc_write_o),
        .reg_write_o (reg_write_o),
        .mem_write_o (mem_write_o),
        .adr_src_o   (adr_src_o),
        .result_src_o(result_src_o),
        .alu_src_a_o (alu_src_a_o),
        .alu_src_b_o (alu_src_b_o),
        .alu_op_o    (alu_op_o),
        .illegal_o   (illegal_o),
        .dbg_state_o (dbg_state_o)
    );

    always #5 clk_i = ~clk_i;

    assign got = {ir_write_o, pc_write_o, reg_write_o, mem_write_o, adr_src_o, result_src_o,
                  alu_src_a_o, alu_src_b_o, alu_op_o, illegal_o};

    // Expected output word for a state, straight from the per-state output table.
    function automatic logic [13:0] exp_outs(int st, bit mr, bit z);
        logic ir = 0, pc = 0, rw = 0, mw = 0, adr = 0, ill = 0;
        logic [1:0] rs = 0, a = 0, b = 0, aop = 0;
        case (st)
            0:  begin ir = mr; pc = mr; b = 2'b10; rs = 2'b10; end
            1:  begin a = 2'b01; b = 2'b01; end
            2:  begin a = 2'b10; b = 2'b01; end
            3:  adr = 1;
            4:  begin rs = 2'b01; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  begin a = 2'b10; aop = 2'b10; end
            7:  begin a = 2'b10; b = 2'b01; aop = 2'b10; end
            8:  rw = 1;
            9:  begin a = 2'b10; aop = 2'b01; pc = z; end
            10: begin a = 2'b01; b = 2'b10; pc = 1; end
            11: ill = 1;
            default: ;
        endcase
        return {ir, pc, rw, mw, adr, rs, a, b, aop, ill};
    endfunction

    task automatic push(int st, bit mr, bit z);
        cyc_t c;
        c.st = st;
        c.mr = mr;
        c.z  = z;
        q.push_back(c);
    endtask

    // Expected cycle sequence of one instruction: fs fetch stalls, ms memory stalls.
    task automatic build(logic [6:0] op, bit z, int fs, int ms);
        q.delete();
        op_i = op;
        for (int i = 0; i < fs; i++) push(0, 1'b0, 1'($urandom));
        push(0, 1'b1, 1'($urandom));
        push(1, 1'($urandom), 1'($urandom));
        case (op)
            OpLw: begin
                push(2, 1'($urandom), 1'($urandom));
                for (int i = 0; i < ms; i++) push(3, 1'b0, 1'($urandom));
                push(3, 1'b1, 1'($urandom));
                push(4, 1'($urandom), 1'($urandom));
            end
            OpSw: begin
                push(2, 1'($urandom), 1'($urandom));
                for (int i = 0; i < ms; i++) push(5, 1'b0, 1'($urandom));
                push(5, 1'b1, 1'($urandom));
            end
            OpRtype: begin push(6, 1'($urandom), 1'($urandom)); push(8, 1'($urandom), 1'($urandom)); end
            OpItype: begin push(7, 1'($urandom), 1'($urandom)); push(8, 1'($urandom), 1'($urandom)); end
            OpBeq:   push(9, 1'($urandom), z);
            OpJal:   begin push(10, 1'($urandom), 1'($urandom)); push(8, 1'($urandom), 1'($urandom)); end
            default: for (int i = 0; i < 12; i++) push(11, 1'($urandom), 1'($urandom));
        endcase
    endtask

    task automatic test_reset();
        mem_ready_i = 1'b0;
        #2;
        n_tests++;
        if (dbg_state_o !== 4'd0 || got !== exp_outs(0, 1'b0, 1'b0)) begin
            n_fail++;
            $display("FAIL reset_mr0: state=%0d outs=%b, expected state=0 outs=%b",
                     dbg_state_o, got, exp_outs(0, 1'b0, 1'b0));
        end
        mem_ready_i = 1'b1;
        #1;
        n_tests++;
        if (got !== exp_outs(0, 1'b1, 1'b0)) begin
            n_fail++;
            $display("FAIL reset_mr1: outs=%b, expected outs=%b", got, exp_outs(0, 1'b1, 1'b0));
        end
        mem_ready_i = 1'b0;
        @(negedge clk_i);
        reset_i = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset_mid_exec();
        op_i = OpRtype;
        mem_ready_i = 1'b1;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        n_tests++;
        if (dbg_state_o !== 4'd6) begin
            n_fail++;
            $display("FAIL mid_exec_reach: state=%0d, expected state=6", dbg_state_o);
        end
        #2;
        reset_i = 1'b1;
        #1;
        n_tests++;
        if (dbg_state_o !== 4'd0 || reg_write_o !== 1'b0 || illegal_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_exec_reset: state=%0d reg_write=%b illegal=%b, expected 0 0 0",
                     dbg_state_o, reg_write_o, illegal_o);
        end
        mem_ready_i = 1'b0;
        @(negedge clk_i);
        reset_i = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_lw();
        build(OpLw, 1'b0, 0, 0);
        foreach (q[i]) begin
            mem_ready_i = q[i].mr; zero_i = q[i].z; #3;
            n_tests++;
            if (dbg_state_o !== 4'(q[i].st) || got !== exp_outs(q[i].st, q[i].mr, q[i].z)) begin
                n_fail++;
                $display("FAIL lw cyc%0d: state=%0d outs=%b, expected state=%0d outs=%b", i,
                         dbg_state_o, got, q[i].st, exp_outs(q[i].st, q[i].mr, q[i].z));
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_sw_stall();
        int mw_cnt = 0;
        build(OpSw, 1'b0, 0, 3);
        foreach (q[i]) begin
            mem_ready_i = q[i].mr; zero_i = q[i].z; #3;
            if (mem_write_o === 1'b1) mw_cnt++;
            n_tests++;
            if (dbg_state_o !== 4'(q[i].st) || got !== exp_outs(q[i].st, q[i].mr, q[i].z)) begin
                n_fail++;
                $display("FAIL sw_stall cyc%0d: state=%0d outs=%b, expected state=%0d outs=%b", i,
                         dbg_state_o, got, q[i].st, exp_outs(q[i].st, q[i].mr, q[i].z));
            end
            @(posedge clk_i); #1;
        end
        n_tests++;
        if (mw_cnt != 4 || dbg_state_o !== 4'd0) begin
            n_fail++;
            $display("FAIL sw_stall_count: mem_write cycles=%0d state=%0d, expected 4 and 0",
                     mw_cnt, dbg_state_o);
        end
    endtask

    task automatic test_beq();
        for (int t = 0; t < 2; t++) begin
            build(OpBeq, 1'(t == 0), t, 0);
            foreach (q[i]) begin
                mem_ready_i = q[i].mr; zero_i = q[i].z; #3;
                n_tests++;
                if (dbg_state_o !== 4'(q[i].st) || got !== exp_outs(q[i].st, q[i].mr, q[i].z)) begin
                    n_fail++;
                    $display("FAIL beq z=%0b cyc%0d: state=%0d outs=%b, expected state=%0d outs=%b",
                             q[i].z, i, dbg_state_o, got, q[i].st,
                             exp_outs(q[i].st, q[i].mr, q[i].z));
                end
                @(posedge clk_i); #1;
            end
        end
    endtask

    task automatic test_jal();
        build(OpJal, 1'b0, 1, 0);
        foreach (q[i]) begin
            mem_ready_i = q[i].mr; zero_i = q[i].z; #3;
            n_tests++;
            if (dbg_state_o !== 4'(q[i].st) || got !== exp_outs(q[i].st, q[i].mr, q[i].z)) begin
                n_fail++;
                $display("FAIL jal cyc%0d: state=%0d outs=%b, expected state=%0d outs=%b", i,
                         dbg_state_o, got, q[i].st, exp_outs(q[i].st, q[i].mr, q[i].z));
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [6];
        ops = '{OpLw, OpSw, OpRtype, OpItype, OpBeq, OpJal};
        for (int n = 0; n < 40; n++) begin
            build(ops[$urandom_range(0, 5)], 1'($urandom), $urandom_range(0, 2),
                  $urandom_range(0, 3));
            foreach (q[i]) begin
                mem_ready_i = q[i].mr; zero_i = q[i].z; #3;
                n_tests++;
                if (dbg_state_o !== 4'(q[i].st) || got !== exp_outs(q[i].st, q[i].mr, q[i].z)) begin
                    n_fail++;
                    $display("FAIL random op=%b cyc%0d: state=%0d outs=%b, expected state=%0d outs=%b",
                             op_i, i, dbg_state_o, got, q[i].st,
                             exp_outs(q[i].st, q[i].mr, q[i].z));
                end
                @(posedge clk_i); #1;
            end
        end
        n_tests++;
        if (dbg_state_o !== 4'd0) begin
            n_fail++;
            $display("FAIL random_end: state=%0d, expected state=0", dbg_state_o);
        end
    endtask

    task automatic test_trap();
        build(OpLui, 1'b0, 0, 0);
        foreach (q[i]) begin
            mem_ready_i = q[i].mr; zero_i = q[i].z; #3;
            n_tests++;
            if (dbg_state_o !== 4'(q[i].st) || got !== exp_outs(q[i].st, q[i].mr, q[i].z)) begin
                n_fail++;
                $display("FAIL trap cyc%0d: state=%0d outs=%b, expected state=%0d outs=%b", i,
                         dbg_state_o, got, q[i].st, exp_outs(q[i].st, q[i].mr, q[i].z));
            end
            @(posedge clk_i); #1;
        end
        #2;
        reset_i = 1'b1;
        #1;
        n_tests++;
        if (illegal_o !== 1'b0 || dbg_state_o !== 4'd0) begin
            n_fail++;
            $display("FAIL trap_clear: illegal=%b state=%0d, expected illegal=0 state=0",
                     illegal_o, dbg_state_o);
        end
        mem_ready_i = 1'b0;
        @(negedge clk_i);
        reset_i = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        test_reset();
        test_reset_mid_exec();
        test_lw();
        test_sw_stall();
        test_beq();
        test_jal();
        test_random();
        test_trap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/main_fsm.md
Name: main_fsm

Overview:
- Multicycle RV32I control FSM, directly upstream of the ALU decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives all datapath enables and muxes, plus the 2-bit ALUOp consumed by the ALU decoder.
- Adds a memory-ready stall handshake and a sticky illegal-opcode trap.

Parameters:
- STATE_W, 4, width of the state register and dbg_state port.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- op  input  7  instruction opcode, from the instruction register (IR) bits [6:0].
- zero  input  1  ALU zero flag, used for beq.
- mem_ready  input  1  memory completes the current access this cycle.
- ir_write  output  1  load the IR and OldPC registers.
- pc_write  output  1  PC register enable.
- reg_write  output  1  register file write enable.
- mem_write  output  1  data memory write strobe.
- adr_src  output  1  memory address select: 0 = PC, 1 = ALU result.
- result_src  output  2  result mux select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- alu_src_a  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
- alu_src_b  output  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4.
- alu_op  output  2  00 = add, 01 = sub (branch), 10 = decode by funct.
- illegal  output  1  sticky illegal-opcode flag.
- dbg_state  output  STATE_W  current state encoding.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - reset asserted forces state = FETCH immediately, regardless of clk.
  - This applies mid-instruction too: any partially executed instruction is abandoned.
- Outputs are combinational from state plus mem_ready/zero, in the same cycle.
- Default for every output not listed for a state: 0.
- Reset values: state FETCH, illegal = 0; outputs take the FETCH decode with mem_ready as sampled.
- State encodings (fixed, for dbg_state): FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5, EXECUTER = 6, EXECUTEI = 7, ALUWB = 8, BEQ = 9, JAL = 10, TRAP = 11.
- Per-state outputs and transitions:
  - FETCH: adr_src = 0, alu_src_a = 00, alu_src_b = 10, alu_op = 00, result_src = 10.
    - ir_write = mem_ready; pc_write = mem_ready.
    - Stays in FETCH while mem_ready = 0; goes to DECODE when mem_ready = 1.
  - DECODE: alu_src_a = 01, alu_src_b = 01, alu_op = 00 (branch target computed into ALUOut).
    - Next state by op:
      - 0000011 (lw) or 0100011 (sw) -> MEMADR
      - 0110011 -> EXECUTER
      - 0010011 -> EXECUTEI
      - 1100011 -> BEQ
      - 1101111 -> JAL
      - any other op -> TRAP
  - MEMADR: alu_src_a = 10, alu_src_b = 01, alu_op = 00.
    - Goes to MEMREAD if op = 0000011, else to MEMWRITE.
  - MEMREAD: adr_src = 1, result_src = 00.
    - Holds until mem_ready = 1, then goes to MEMWB.
  - MEMWB: result_src = 01, reg_write = 1; then FETCH.
  - MEMWRITE: adr_src = 1, result_src = 00, mem_write = 1.
    - mem_write stays asserted on every cycle of a stall.
    - Holds until mem_ready = 1, then goes to FETCH.
  - EXECUTER: alu_src_a = 10, alu_src_b = 00, alu_op = 10; then ALUWB.
  - EXECUTEI: alu_src_a = 10, alu_src_b = 01, alu_op = 10; then ALUWB.
  - ALUWB: result_src = 00, reg_write = 1; then FETCH.
  - BEQ: alu_src_a = 10, alu_src_b = 00, alu_op = 01, result_src = 00.
    - pc_write = zero.
    - Then FETCH, whether or not the branch is taken.
  - JAL: alu_src_a = 01, alu_src_b = 10, alu_op = 00, result_src = 00, pc_write = 1; then ALUWB.
  - TRAP: all enables 0, illegal = 1.
    - Stays in TRAP until reset.
- op is sampled in DECODE and MEMADR only. It must be stable from the ir_write cycle until the next FETCH.
- Never assert reg_write and mem_write in the same cycle, and never assert ir_write outside FETCH.
- Instruction cycle counts with mem_ready tied to 1:
  - lw = 5
  - sw = 4
  - R-type = 4
  - I-type = 4
  - beq = 3
  - jal = 4

Test Plan:
- Reset asserted mid-EXECUTER, asynchronously between clock edges -> dbg_state = 0 immediately (before the next edge); reg_write = 0; illegal = 0.
- mem_ready = 1, op = 0000011 -> state sequence 0, 1, 2, 3, 4, 0; reg_write = 1 only in state 4, with result_src = 01.
- op = 0100011, mem_ready low for 3 cycles in MEMWRITE -> mem_write = 1 for 4 consecutive cycles; adr_src = 1 throughout; then FETCH.
- op = 1100011:
  - zero = 1 -> pc_write = 1 in BEQ, with alu_op = 01.
  - zero = 0 -> pc_write = 0.
  - Both cases return to FETCH.
- op = 1101111 -> sequence FETCH, DECODE, JAL (pc_write = 1, alu_src_b = 10), ALUWB (reg_write = 1), FETCH.
- op = 0110111 (unsupported) -> TRAP after DECODE; illegal = 1 held for 10+ cycles with all enables 0; cleared only by reset.
